// File: rtl/gol_pkg.sv
// Shared types and constants for the cellular-automaton board:
// the control state encoding and the neighbour-count helper.
package gol_pkg;

    localparam int NBR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } gol_state_e;

    function automatic logic [NBR_W-1:0] count_live(input logic [7:0] nbrs);
        logic [NBR_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + NBR_W'(nbrs[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/gol_if.sv
// Control and observation bundle for gol_board.
// Command pulses are single-cycle strobes sampled on posedge clk; load_valid is a
// valid-only qualifier (no ready): every cycle it is high in LOAD consumes one load_bit.
interface gol_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                   load_start;
    logic                   load_valid;
    logic                   load_bit;
    logic                   start;
    logic                   stop;
    logic                   step;
    logic [ROWS*COLS-1:0]   grid;
    logic [15:0]            generation;
    logic [1:0]             state;
    logic                   stable;
    logic                   extinct;

    modport master (
        output load_start, load_valid, load_bit, start, stop, step,
        input  grid, generation, state, stable, extinct
    );

    modport slave (
        input  load_start, load_valid, load_bit, start, stop, step,
        output grid, generation, state, stable, extinct
    );
endinterface

// File: rtl/gol_cell.sv
// One cell's next-state rule: count live neighbours and look the result up
// in the birth or survive mask depending on the current value.
module gol_cell
    import gol_pkg::*;
(
    input  logic [7:0] neighbours,
    input  logic       current,
    input  logic [8:0] birth_mask,
    input  logic [8:0] survive_mask,
    output logic       next
);
    logic [NBR_W-1:0] live_cnt;

    assign live_cnt = count_live(neighbours);
    assign next     = current ? survive_mask[live_cnt] : birth_mask[live_cnt];
endmodule

// File: rtl/gol_board.sv
// Cellular-automaton board with serial load, single step and free run with auto-halt.
// Build option: define GOL_TORUS_EN to wrap the neighbourhood around the edges.
module gol_board
    import gol_pkg::*;
#(
    parameter int         ROWS         = 8,
    parameter int         COLS         = 8,
    parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
    input logic  clk,
    input logic  reset,
    gol_if.slave bus
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    gol_state_e       state_q, state_d;
    logic [CELLS-1:0] grid_q, grid_d, next_grid;
    logic [15:0]      gen_q, gen_d, gen_inc;
    logic             stable_q, stable_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Neighbour bit k covers offsets (k/3-1, k%3-1), skipping the centre.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic [7:0] nbrs;
            for (genvar k = 0; k < 9; k++) begin : g_nbr
                if (k != 4) begin : g_used
                    localparam int NR  = gr + k / 3 - 1;
                    localparam int NC  = gc + k % 3 - 1;
                    localparam int BIT = (k < 4) ? k : k - 1;
`ifdef GOL_TORUS_EN
                    localparam int WR = (NR + ROWS) % ROWS;
                    localparam int WC = (NC + COLS) % COLS;
                    assign nbrs[BIT] = grid_q[WR*COLS+WC];
`else
                    if (NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_in
                        assign nbrs[BIT] = grid_q[NR*COLS+NC];
                    end else begin : g_out
                        assign nbrs[BIT] = 1'b0;
                    end
`endif
                end
            end
            gol_cell u_cell (
                .neighbours   (nbrs),
                .current      (grid_q[gr*COLS+gc]),
                .birth_mask   (BIRTH_MASK),
                .survive_mask (SURVIVE_MASK),
                .next         (next_grid[gr*COLS+gc])
            );
        end
    end

    assign gen_inc = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            idx_q    <= idx_d;
        end
    end

    // Command priority: load_start, then stop, then start, then step.
    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        idx_d    = idx_q;
        if (bus.load_start) begin
            state_d  = LOAD;
            idx_d    = '0;
            stable_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (bus.load_valid) begin
                        grid_d[idx_q] = bus.load_bit;
                        if (idx_q == IDX_W'(CELLS - 1)) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            gen_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (!bus.stop) begin
                        if (bus.start) begin
                            state_d = RUN;
                        end else if (bus.step) begin
                            grid_d   = next_grid;
                            gen_d    = gen_inc;
                            stable_d = (next_grid == grid_q);
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                    end else if (next_grid == grid_q) begin
                        stable_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        grid_d   = next_grid;
                        gen_d    = gen_inc;
                        stable_d = 1'b0;
                        if (next_grid == '0) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.grid       = grid_q;
    assign bus.generation = gen_q;
    assign bus.state      = state_q;
    assign bus.stable     = stable_q;
    assign bus.extinct    = ~|grid_q;
endmodule

// File: tb/tb_gol_board.sv
// Randomized self-checking bench for gol_board: a 5x5 and an 8x8 board checked
// against an array-based model of the life rules.
module tb_gol_board;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic clk, rst;
  logic ls, lv, lb, st, sp, stp;
  bit   use5;
  int   rows, cols;

  logic [63:0] mgrid;
  logic [15:0] mgen;
  logic        mstable;
  logic [63:0] exp_q[$];
  int          vectors, miscompares;

  logic [63:0] obs_grid;
  logic [15:0] obs_gen;
  logic [1:0]  obs_state;
  logic        obs_stable, obs_extinct;

  gol_if #(.ROWS(5), .COLS(5)) b5 ();
  gol_if #(.ROWS(8), .COLS(8)) b8 ();

  assign b5.load_start = use5 & ls;
  assign b5.load_valid = use5 & lv;
  assign b5.load_bit   = lb;
  assign b5.start      = use5 & st;
  assign b5.stop       = use5 & sp;
  assign b5.step       = use5 & stp;
  assign b8.load_start = ~use5 & ls;
  assign b8.load_valid = ~use5 & lv;
  assign b8.load_bit   = lb;
  assign b8.start      = ~use5 & st;
  assign b8.stop       = ~use5 & sp;
  assign b8.step       = ~use5 & stp;

  gol_board #(.ROWS(5), .COLS(5)) dut5 (.clk(clk), .reset(rst), .bus(b5));
  gol_board #(.ROWS(8), .COLS(8)) dut8 (.clk(clk), .reset(rst), .bus(b8));

  always_comb begin
    if (use5) begin
      obs_grid    = {39'd0, b5.grid};
      obs_gen     = b5.generation;
      obs_state   = b5.state;
      obs_stable  = b5.stable;
      obs_extinct = b5.extinct;
    end else begin
      obs_grid    = b8.grid;
      obs_gen     = b8.generation;
      obs_state   = b8.state;
      obs_stable  = b8.stable;
      obs_extinct = b8.extinct;
    end
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: apply B3/S23 over an explicit row/column array walk.
  function automatic logic [63:0] next_gen(input logic [63:0] g);
    logic [63:0] res;
    res = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
`ifdef GOL_TORUS_EN
            rr = (rr + rows) % rows;
            cc = (cc + cols) % cols;
`endif
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < rows && cc >= 0 && cc < cols)
              if (g[rr*cols+cc]) n++;
          end
        end
        if (g[r*cols+c]) res[r*cols+c] = (n == 2 || n == 3);
        else             res[r*cols+c] = (n == 3);
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input bit five);
    use5 = five;
    rows = five ? 5 : 8;
    cols = five ? 5 : 8;
  endtask

  task automatic load_grid(input string tag, input logic [63:0] g);
    ls = 1'b1; tick(); ls = 1'b0;
    check({tag, " enter_load"}, obs_state, ST_LOAD);
    for (int i = 0; i < rows * cols; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        lv = 1'b0; lb = 1'($urandom_range(0, 1)); tick();
      end
      lv = 1'b1; lb = g[i]; tick();
    end
    lv = 1'b0;
    mgrid = g; mgen = '0; mstable = 1'b0;
    check({tag, " load_state"}, obs_state, ST_IDLE);
    check({tag, " load_gen"}, obs_gen, 0);
    check({tag, " load_grid"}, obs_grid, g);
    lv = 1'b1; lb = 1'b1; tick(); lv = 1'b0;
    check({tag, " idle_bits_ignored"}, obs_grid, g);
  endtask

  task automatic do_step(input string tag);
    logic [63:0] nxt;
    nxt = next_gen(mgrid);
    stp = 1'b1; tick(); stp = 1'b0;
    mstable = (nxt == mgrid);
    mgrid = nxt;
    mgen = sat_inc(mgen);
    check({tag, " step_grid"}, obs_grid, mgrid);
    check({tag, " step_gen"}, obs_gen, mgen);
    check({tag, " step_state"}, obs_state, ST_IDLE);
    check({tag, " step_stable"}, obs_stable, mstable);
  endtask

  // Builds the expected trajectory into exp_q, then runs the board and scores it.
  task automatic run_check(input string tag, input int limit);
    logic [63:0] g, nxt, e;
    bit halted, stab;
    exp_q.delete();
    g = mgrid; halted = 0; stab = 0;
    while (exp_q.size() < limit && !halted) begin
      nxt = next_gen(g);
      if (nxt == g) begin
        stab = 1; halted = 1;
      end else begin
        g = nxt;
        if (g == '0) halted = 1;
      end
      exp_q.push_back(g);
    end
    st = 1'b1; tick(); st = 1'b0;
    check({tag, " run_entered"}, obs_state, ST_RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      if (!(stab && exp_q.size() == 0)) mgen = sat_inc(mgen);
      mgrid = e;
      check({tag, " run_grid"}, obs_grid, mgrid);
      check({tag, " run_gen"}, obs_gen, mgen);
    end
    if (!halted) begin
      sp = 1'b1; tick(); sp = 1'b0;
      check({tag, " stop_grid_held"}, obs_grid, mgrid);
    end
    mstable = stab;
    check({tag, " end_state"}, obs_state, ST_IDLE);
    check({tag, " end_stable"}, obs_stable, mstable);
    check({tag, " end_extinct"}, obs_extinct, mgrid == '0);
  endtask

  function automatic logic [63:0] rand_soup(input int ncells);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < ncells; i++) g[i] = ($urandom_range(0, 2) == 0);
    return g;
  endfunction

  initial begin
    logic [63:0] pat, vert, glider, blk_tl, blk_tr, blk_bl, blk_br;
    vectors = 0; miscompares = 0;
    ls = 0; lv = 0; lb = 0; st = 0; sp = 0; stp = 0;
    mgrid = '0; mgen = '0; mstable = 1'b0;
    select(0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst8 grid", obs_grid, 0);
    check("rst8 gen", obs_gen, 0);
    check("rst8 state", obs_state, ST_IDLE);
    check("rst8 stable", obs_stable, 0);
    check("rst8 extinct", obs_extinct, 1);
    select(1);
    check("rst5 grid", obs_grid, 0);
    check("rst5 state", obs_state, ST_IDLE);
    rst = 1'b0;
    tick();

    // 5x5 blinker
    pat = '0; pat[11] = 1; pat[12] = 1; pat[13] = 1;
    vert = '0; vert[7] = 1; vert[12] = 1; vert[17] = 1;
    load_grid("blinker", pat);
    do_step("blinker1");
    check("blinker1 vertical", obs_grid, vert);
    check("blinker1 gen_is_1", obs_gen, 1);
    do_step("blinker2");
    check("blinker2 horizontal", obs_grid, pat);
    check("blinker2 gen_is_2", obs_gen, 2);
    st = 1'b1; stp = 1'b1; tick(); st = 1'b0; stp = 1'b0;
    check("start_over_step state", obs_state, ST_RUN);
    check("start_over_step grid", obs_grid, mgrid);
    sp = 1'b1; tick(); sp = 1'b0;
    check("stop state", obs_state, ST_IDLE);
    check("stop grid", obs_grid, mgrid);
    check("stop gen", obs_gen, mgen);
    for (int t = 0; t < 3; t++) begin
      load_grid("rand5", rand_soup(25));
      repeat (3) do_step("rand5");
    end

    // 8x8 still life
    select(0);
    pat = '0; pat[27] = 1; pat[28] = 1; pat[35] = 1; pat[36] = 1;
    load_grid("block", pat);
    run_check("block", 10);
    check("block grid_unchanged", obs_grid, pat);
    check("block gen_zero", obs_gen, 0);
    check("block stable", obs_stable, 1);

    // 8x8 lone cell dies in one advance
    pat = '0; pat[36] = 1;
    load_grid("single", pat);
    run_check("single", 10);
    check("single gen_one", obs_gen, 1);
    check("single extinct", obs_extinct, 1);

    for (int t = 0; t < 3; t++) begin
      load_grid("rand8", rand_soup(64));
      run_check("rand8", 30);
    end

    // glider from top-left
    glider = '0; glider[1] = 1; glider[10] = 1; glider[16] = 1; glider[17] = 1; glider[18] = 1;
    load_grid("glider", glider);
`ifdef GOL_TORUS_EN
    run_check("glider_torus", 32);
    check("glider_torus back_home", obs_grid, glider);
    check("glider_torus gen32", obs_gen, 32);
`else
    run_check("glider_flat", 120);
    blk_tl = 64'h0000_0000_0000_0303;
    blk_tr = 64'h0000_0000_0000_C0C0;
    blk_bl = 64'h0303_0000_0000_0000;
    blk_br = 64'hC0C0_0000_0000_0000;
    check("glider_flat corner_block",
          (obs_grid == blk_tl) || (obs_grid == blk_tr) || (obs_grid == blk_bl) || (obs_grid == blk_br), 1);
    check("glider_flat stable", obs_stable, 1);
`endif

    // asynchronous reset in the middle of a run
    load_grid("rst_run", glider);
    st = 1'b1; tick(); st = 1'b0;
    repeat (5) tick();
    check("rst_run gen5", obs_gen, 5);
    check("rst_run still_running", obs_state, ST_RUN);
    #2 rst = 1'b1;
    #1;
    check("rst_run grid", obs_grid, 0);
    check("rst_run gen", obs_gen, 0);
    check("rst_run state", obs_state, ST_IDLE);
    #1 rst = 1'b0;
    tick();
    ls = 1'b1; st = 1'b1; tick(); ls = 1'b0; st = 1'b0;
    check("load_over_start state", obs_state, ST_LOAD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gol_board.md
GOL_BOARD -- requirements
Module: gol_board

Interface
REQ-001 ROWS, 8, grid height in cells (>=3).
REQ-002 COLS, 8, grid width in cells (>=3).
REQ-003 BIRTH_MASK, 9'b000001000, bit n set: a dead cell with n live neighbours is born.
REQ-004 SURVIVE_MASK, 9'b000001100, bit n set: a live cell with n live neighbours survives.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 load_start  input  1  pulse: enter LOAD and clear the load index.
REQ-008 load_valid  input  1  qualifies load_bit in LOAD.
REQ-009 load_bit  input  1  serial cell value, row-major, cell (0,0) first.
REQ-010 start  input  1  pulse: IDLE -> RUN.
REQ-011 stop  input  1  pulse: RUN -> IDLE.
REQ-012 step  input  1  pulse in IDLE: compute exactly one generation.
REQ-013 grid  output  ROWS*COLS  cell state; bit r*COLS+c = cell (r,c).
REQ-014 generation  output  16  generations computed since last load.
REQ-015 state  output  2  IDLE=0, LOAD=1, RUN=2.
REQ-016 stable  output  1  last evaluated next grid equalled the current grid.
REQ-017 extinct  output  1  grid is all zero.

Function
REQ-018 Next state of each cell SHALL be SURVIVE_MASK[n] if live, else BIRTH_MASK[n], where n is its 0..8 live-neighbour count.
REQ-019 The entire grid SHALL update in one cycle; no cell uses a partially updated neighbour.
REQ-020 LOAD: each cycle with load_valid=1 SHALL write load_bit to cell at load index and increment it; after ROWS*COLS bits state SHALL return to IDLE with generation=0 the following cycle.
REQ-021 load_valid=0 in LOAD SHALL hold the index; bits SHALL be ignored outside LOAD.
REQ-022 IDLE + step: grid SHALL take the next generation on that edge; generation +1; state stays IDLE.
REQ-023 RUN: grid SHALL advance one generation per cycle; generation +1 per advance.
REQ-024 RUN auto-halt: if next grid equals current grid, grid and generation SHALL hold, stable=1, state -> IDLE.
REQ-025 RUN auto-halt: if an advance yields an all-zero grid, that advance SHALL complete, then state -> IDLE.
REQ-026 Priority per cycle: load_start > stop > start > step; start/step ignored outside IDLE; load_start in RUN or LOAD SHALL restart LOAD.
REQ-027 generation SHALL saturate at 16'hFFFF; grid keeps advancing.
REQ-028 stable SHALL clear on load_start or on any grid change; extinct is combinational from grid.

Reset
REQ-029 reset SHALL asynchronously force grid=0, generation=0, state=IDLE, stable=0, load index=0; a RUN or LOAD in progress is abandoned.

Configuration
REQ-030 GOL_TORUS_EN defined: neighbours wrap (row 0 adjoins row ROWS-1, col 0 adjoins col COLS-1).
REQ-031 GOL_TORUS_EN undefined: neighbours outside the grid SHALL count as dead.

Structure
REQ-032 Package gol_pkg SHALL hold the state enum (IDLE, LOAD, RUN) and the neighbour-count width constant (4).
REQ-033 Sub-module gol_cell (neighbours[7:0], current, masks -> next) SHALL be instantiated ROWS*COLS times via generate; the FSM, load index and counters live in gol_board.

Verification
REQ-034 5x5 board, load horizontal blinker cells (2,1),(2,2),(2,3); step -> cells (1,2),(2,2),(3,2) live, generation=1; step -> original, generation=2.
REQ-035 8x8, 2x2 block at (3,3); start -> state IDLE within 2 cycles, generation=0, stable=1, grid unchanged.
REQ-036 8x8, single cell (4,4); start -> one advance, grid=0, extinct=1, generation=1, state IDLE.
REQ-037 8x8 with GOL_TORUS_EN, glider at top-left; start, stop after 32 generations -> grid equals load pattern; without macro, glider settles into a 2x2 block at a corner.
REQ-038 Assert reset mid-RUN at generation=5 -> grid=0, generation=0, state IDLE immediately; load_start with start in same cycle -> LOAD entered.
